// File: rtl/inter_packet_delay_pkg.sv
// Shared types and constants for the inter-packet gap stage.
// Holds FSM encodings, the tuser delay field bounds and counter helpers.
package inter_packet_delay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ipd_state_t;

    localparam int unsigned TUSER_DELAY_LO = 32;
    localparam int unsigned TUSER_DELAY_HI = 63;
    localparam int unsigned CNT_W          = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/inter_packet_delay.sv
// Enforces a minimum idle gap between packets on an AXI-Stream path.
// Data is combinational; only the first-beat handshake is gated.
module inter_packet_delay
    import inter_packet_delay_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    input  logic                                 sw_rst,
    input  logic                                 ipd_en,
    input  logic                                 use_reg_delay,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        delay_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        stall_count
);

    ipd_state_t        r_state;
    ipd_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_g;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_en_act;

    logic              w_rst;
    logic [CNT_W-1:0]  w_delay;
    logic              w_en_live;
    logic              w_open;
    logic              w_hs;
    logic              w_last_hs;

    assign w_rst = axi_reset | sw_rst;

    assign w_delay = use_reg_delay ? delay_reg
                                   : s_axis_tuser[TUSER_DELAY_HI:TUSER_DELAY_LO];

    // Between packets the enable is taken live; inside a packet it is frozen.
    assign w_en_live = (r_state == IDLE) ? ipd_en : r_en_act;

    assign w_open = (r_state == SEND) || !w_en_live || (r_g >= w_delay);

    assign w_hs      = s_axis_tvalid & m_axis_tready & w_open;
    assign w_last_hs = w_hs & s_axis_tlast;

    assign m_axis_tvalid = s_axis_tvalid & w_open;
    assign s_axis_tready = m_axis_tready & w_open;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;

    assign pkt_count   = r_pkt_cnt;
    assign stall_count = r_stall_cnt;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_hs && !s_axis_tlast) w_state_nxt = SEND;
            SEND: if (w_last_hs)             w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (w_rst) begin
            r_state     <= IDLE;
            r_g         <= '1;
            r_en_act    <= 1'b0;
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_last_hs) r_g <= '0;
            else           r_g <= sat_inc(r_g);
            if (r_state == IDLE) r_en_act <= ipd_en;
            if (w_last_hs) r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if ((r_state == IDLE) && s_axis_tvalid && !w_open)
                r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule

// File: tb/tb_inter_packet_delay.sv
// Directed and randomized bench for inter_packet_delay.
// A cycle-timestamp reference model predicts gating and counters.
module tb_inter_packet_delay;

    logic         clk = 1'b0;
    logic         axi_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         sw_rst;
    logic         ipd_en;
    logic         use_reg_delay;
    logic [31:0]  delay_reg;
    logic [31:0]  pkt_count;
    logic [31:0]  stall_count;

    always #5 clk = ~clk;

    inter_packet_delay dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sw_rst        (sw_rst),
        .ipd_en        (ipd_en),
        .use_reg_delay (use_reg_delay),
        .delay_reg     (delay_reg),
        .pkt_count     (pkt_count),
        .stall_count   (stall_count)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // Reference model: packet boundaries as cycle timestamps.
    bit     m_in_pkt   = 0;
    bit     m_never    = 1;
    longint m_last_end = 0;
    bit     m_en       = 0;
    int     m_pkts     = 0;
    int     m_stalls   = 0;

    bit     rand_tr = 0;
    int     tr_low  = 0;
    bit     hs_now;
    longint hs_cyc;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] d;
        longint      idle;
        bit          en_l, open, rst;
        m_axis_tready = rand_tr ? ($urandom % 4 != 0) : (tr_low == 0);
        if (tr_low > 0) tr_low--;
        @(negedge clk);
        rst  = axi_reset | sw_rst;
        d    = use_reg_delay ? delay_reg : s_axis_tuser[63:32];
        en_l = m_in_pkt ? m_en : ipd_en;
        if (m_never) idle = 64'hFFFF_FFFF;
        else begin
            idle = cyc - m_last_end - 1;
            if (idle > 64'hFFFF_FFFF) idle = 64'hFFFF_FFFF;
        end
        open = m_in_pkt || !en_l || (idle >= longint'(d));
        chk("tvalid", m_axis_tvalid, s_axis_tvalid & open);
        chk("tready", s_axis_tready, m_axis_tready & open);
        chk("data", {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast},
            {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast});
        chk("pkt_count", pkt_count, m_pkts);
        chk("stall_count", stall_count, m_stalls);
        hs_now = s_axis_tvalid & m_axis_tready & open;
        if (hs_now) hs_cyc = cyc;
        if (rst) begin
            m_in_pkt = 0; m_never = 1; m_en = 0; m_pkts = 0; m_stalls = 0;
        end else begin
            if (!m_in_pkt) begin
                m_en = ipd_en;
                if (s_axis_tvalid && !open) m_stalls++;
            end
            if (hs_now) begin
                if (s_axis_tlast) begin
                    m_pkts++; m_last_end = cyc; m_never = 0; m_in_pkt = 0;
                end else m_in_pkt = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beat(input bit last, input logic [31:0] tud);
        int n = 0;
        s_axis_tvalid = 1;
        s_axis_tlast  = last;
        s_axis_tdata  = {8{$urandom}};
        s_axis_tstrb  = $urandom;
        s_axis_tuser  = {$urandom, $urandom, tud, $urandom};
        hs_now = 0;
        while (!hs_now && n < 2000) begin
            tick();
            n++;
        end
        if (!hs_now) begin
            total++; bad++;
            $error("FAIL timeout got=%0d exp=handshake", n);
        end
    endtask

    task automatic send_pkt(input int beats, input logic [31:0] tud);
        for (int b = 0; b < beats; b++) send_beat(b == beats - 1, tud);
    endtask

    initial begin
        longint t0, t1;
        int     s0;
        axi_reset = 1; sw_rst = 0; ipd_en = 0; use_reg_delay = 1;
        delay_reg = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        m_axis_tready = 1;
        @(posedge clk); #1;
        tick(); tick();
        axi_reset = 0;
        tick();

        // Enforcement off: three 4-beat packets with no bubbles.
        send_beat(0, 0);
        t0 = hs_cyc;
        send_beat(0, 0); send_beat(0, 0); send_beat(1, 0);
        send_pkt(4, 0);
        send_pkt(4, 0);
        chk("t1_span", hs_cyc - t0, 11);
        chk("t1_pkts", pkt_count, 3);
        chk("t1_stall", stall_count, 0);

        // Register delay 10 with 2-beat packets.
        ipd_en = 1; use_reg_delay = 1; delay_reg = 10;
        send_pkt(2, 0);
        for (int p = 0; p < 3; p++) begin
            t0 = hs_cyc;
            s0 = stall_count;
            send_beat(0, 0);
            chk("t2_gap", hs_cyc - t0, 11);
            chk("t2_stall", stall_count - s0, 10);
            send_beat(1, 0);
        end

        // Per-packet tuser delays on single beats.
        use_reg_delay = 0;
        t0 = hs_cyc; send_beat(1, 0); chk("t3_gap0", hs_cyc - t0, 1);
        t0 = hs_cyc; send_beat(1, 5); chk("t3_gap5", hs_cyc - t0, 6);
        t0 = hs_cyc; send_beat(1, 3); chk("t3_gap3", hs_cyc - t0, 4);

        // Backpressure time counts toward the gap.
        use_reg_delay = 1; delay_reg = 4;
        send_beat(1, 0);
        t0 = hs_cyc;
        tr_low = 6;
        send_beat(1, 0);
        chk("t4_bp", hs_cyc - t0, 7);

        // ipd_en raised mid-packet, then sw_rst mid-packet.
        ipd_en = 0; delay_reg = 20;
        send_beat(1, 0);
        send_beat(0, 0); t0 = hs_cyc;
        send_beat(0, 0);
        ipd_en = 1;
        send_beat(0, 0); send_beat(1, 0);
        chk("t5_cont", hs_cyc - t0, 3);
        send_beat(0, 0); send_beat(0, 0);
        s_axis_tvalid = 0;
        sw_rst = 1;
        tick();
        sw_rst = 0;
        chk("t5_pkts", pkt_count, 0);
        chk("t5_stall", stall_count, 0);
        t1 = cyc;
        send_beat(1, 0);
        chk("t5_nodly", hs_cyc - t1, 0);

        // Randomized traffic against the model.
        rand_tr = 1;
        for (int p = 0; p < 40; p++) begin
            int beats;
            beats         = int'($urandom_range(1, 4));
            ipd_en        = $urandom_range(0, 3) != 0;
            use_reg_delay = $urandom_range(0, 1);
            delay_reg     = $urandom_range(0, 8);
            send_pkt(beats, $urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 5)));
        end
        rand_tr = 0;
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inter_packet_delay.md
# inter_packet_delay

Generator-path stage placed directly downstream of the rate limiter, before the output port. It enforces a minimum idle gap, in `axi_aclk` cycles, between the last beat of one packet and the first beat of the next. The gap comes either from a software register or from a per-packet field in `tuser` written by the replay engine. Data passes through combinationally; only the packet-start handshake is gated.

## Interface
Parameters:
- `C_M_AXIS_DATA_WIDTH`, 256, master tdata width
- `C_S_AXIS_DATA_WIDTH`, 256, slave tdata width (must equal master)
- `C_M_AXIS_TUSER_WIDTH`, 128, master tuser width
- `C_S_AXIS_TUSER_WIDTH`, 128, slave tuser width (must equal master)
- `C_S_AXI_DATA_WIDTH`, 32, width of delay register and counters

Ports:
- `axi_aclk` in 1: the single clock
- `axi_reset` in 1: **synchronous, active-high** reset
- `s_axis_tdata/tstrb/tuser/tvalid/tlast` in: packet input from rate limiter
- `s_axis_tready` out 1
- `m_axis_tdata/tstrb/tuser/tvalid/tlast` out: packet output
- `m_axis_tready` in 1
- `sw_rst` in 1: software reset, same effect as `axi_reset`
- `ipd_en` in 1: enable gap enforcement
- `use_reg_delay` in 1: 1 = gap from `delay_reg`; 0 = gap from `s_axis_tuser[63:32]`
- `delay_reg` in 32: register gap in cycles
- `pkt_count` out 32: packets forwarded, wraps
- `stall_count` out 32: cycles a valid first beat was held back, saturates

## Operation
- FSM states:
  - IDLE: no packet in flight.
  - SEND: a multi-beat packet has started.
- IDLE → SEND on a first-beat handshake with `tlast=0`.
- SEND → IDLE on a `tlast` handshake.
- A single-beat packet stays in IDLE.
- Gap counter `g` (32 bit, saturating at all-ones):
  - Cleared to 0 in the cycle of any output `tlast` handshake.
  - Otherwise increments by 1 every cycle.
  - Reset value is all-ones, so the first packet after reset is never delayed.
- Delay `D` = `delay_reg` when `use_reg_delay=1`, else `s_axis_tuser[63:32]`.
  - `D` is evaluated live from the current first beat while in IDLE.
  - `tuser` is stable while valid is held, per AXIS.
- `en_act` latches `ipd_en` at each packet start, i.e. while in IDLE. Toggling `ipd_en` mid-packet has no effect until the next packet.
- Gate:
  - `open` = (state==SEND) || !en_act_live || (g >= D), unsigned compare.
  - `m_axis_tvalid` = `s_axis_tvalid & open`.
  - `s_axis_tready` = `m_axis_tready & open`.
  - tdata/tstrb/tuser/tlast wired straight through.
- `pkt_count` increments on each output `tlast` handshake.
- `stall_count` increments each IDLE cycle with `s_axis_tvalid=1 & !open`.

## Timing
- Data latency 0 cycles: combinational tvalid/tready/data path.
- Gap definition: `tlast` handshake in cycle t with D = N → next first beat may handshake at cycle t+N+1 or later (N full idle cycles in between).
  - D=0 permits back-to-back packets.
- Reset values: state IDLE, `g` all-ones, `en_act` 0, `pkt_count` 0, `stall_count` 0.
- Outputs during reset: `m_axis_tvalid` follows gate, using the reset values.
- `sw_rst` mid-packet:
  - The FSM returns to IDLE and the downstream packet is truncated with no `tlast`.
  - Software must quiesce the upstream first; this is documented, not corrected.
- Backpressure: `m_axis_tready=0` freezes the handshake. `g` keeps counting, so waiting for tready counts toward the gap.
- `delay_reg` changed during a wait takes effect in the next cycle's compare.
- `g` saturation: gaps above 2^32−2 cycles behave as "always open" once saturated.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=0, SEND=1).
  - Tuser delay field bounds: `TUSER_DELAY_LO`=32, `TUSER_DELAY_HI`=63.
  - Saturating-counter width.
- No sub-module; one file.
- Register mapping lives in the enclosing pcore wrapper, alongside the rate limiter's AXI-lite register block.

## Test plan
- Reset, `ipd_en=0`, three 4-beat packets back-to-back with tready=1 → output identical to input, zero bubbles, `pkt_count`=3, `stall_count`=0.
- `ipd_en=1`, `use_reg_delay=1`, `delay_reg=10`, continuous input of 2-beat packets:
  - Each first beat handshakes exactly 11 cycles after the previous `tlast` handshake.
  - `stall_count` increases by 10 per packet after the first.
- `use_reg_delay=0`, tuser[63:32] = 0, 5, 3 on consecutive single-beat packets → gaps of 0, 5, 3 idle cycles (D taken from the waiting packet).
- `delay_reg=4`, `m_axis_tready` low for 6 cycles after a `tlast` → next packet handshakes on the first tready-high cycle, no extra wait.
- `ipd_en` raised mid-packet, then `sw_rst` mid-packet:
  - The current packet is unaffected by `ipd_en`.
  - After `sw_rst`: state IDLE, counters 0, and the next packet passes with no delay (g saturated).
